pulse_meas: RTL and testbench

PULSE_MEAS -- requirements
Module: pulse_meas

---
 rtl/pulse_meas_pkg.sv | 13 +
 rtl/glitch_filter.sv | 43 ++++
 rtl/pulse_meas.sv | 105 ++++++++++
 tb/tb_pulse_meas.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg: shared types and defaults for the pulse width meter.
// Holds the level-tracking FSM state and default parameter values.
package pulse_meas_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  localparam int STABLE_CYC_DEF = 2;
  localparam int WIDTH_W_DEF    = 8;

endpackage

// File: rtl/glitch_filter.sv
// glitch_filter: two-flop synchronizer followed by a stability filter.
// Ports: clk, rst_n (sync, active-low), d (async in), level (filtered out).
module glitch_filter
  import pulse_meas_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level
);

  localparam logic [3:0] LAST = 4'(STABLE_CYC - 1);

  logic       s1;
  logic       s2;
  logic [3:0] cnt;

  // cnt holds how many consecutive synced samples have disagreed
  // with level; the disagreement that would make it STABLE_CYC flips
  // level instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pulse_meas.sv
// pulse_meas: measures high time of a debounced input, valid/ready out.
// Ports: clk, rst_n, d -> level, rise, out_valid/out_ready, out_width,
// out_sat, overrun (sticky drop), pulse_cnt (filtered rising edges).
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int WIDTH_W    = WIDTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d,
  output logic               level,
  output logic               rise,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_W-1:0] out_width,
  output logic               out_sat,
  output logic               overrun,
  output logic [15:0]        pulse_cnt
);

  localparam logic [WIDTH_W-1:0] WMAX = '1;
  localparam logic [WIDTH_W-1:0] WONE = WIDTH_W'(1);

  state_t             state_q;
  state_t             state_d;
  logic               fall;
  logic               xfer;
  logic [WIDTH_W-1:0] wcnt;
  logic               wsat;

  glitch_filter #(
    .STABLE_CYC(STABLE_CYC)
  ) u_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .level(level)
  );

  assign xfer = out_valid & out_ready;

  // state lags level by one cycle, so the first cycle of a new
  // level is seen as the edge cycle.
  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    fall    = 1'b0;
    unique case (state_q)
      LOW: begin
        if (level) begin
          state_d = HIGH;
          rise    = 1'b1;
        end
      end
      HIGH: begin
        if (!level) begin
          state_d = LOW;
          fall    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOW;
      wcnt      <= '0;
      wsat      <= 1'b0;
      out_valid <= 1'b0;
      out_width <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state_q <= state_d;

      // the rise cycle itself counts as the first high cycle
      if (rise) begin
        wcnt      <= WONE;
        wsat      <= 1'b0;
        pulse_cnt <= pulse_cnt + 16'd1;
      end else if (state_q == HIGH && level) begin
        if (wcnt == WMAX) begin
          wsat <= 1'b1;
        end else begin
          wcnt <= wcnt + WONE;
        end
      end

      // a finished pulse may replace data that transfers this edge
      if (fall && (!out_valid || xfer)) begin
        out_width <= wcnt;
        out_sat   <= wsat;
        out_valid <= 1'b1;
      end else if (fall) begin
        overrun <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas: directed + random stimulus against a pulse-level model.
// Model works on sampled input history and pulse start/end times.
module tb_pulse_meas;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d = 1'b0;
  logic       out_ready = 1'b0;
  logic       level;
  logic       rise;
  logic       out_valid;
  logic [7:0] out_width;
  logic       out_sat;
  logic       overrun;
  logic [15:0] pulse_cnt;

  pulse_meas #(
    .STABLE_CYC(S),
    .WIDTH_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .level    (level),
    .rise     (rise),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_width(out_width),
    .out_sat  (out_sat),
    .overrun  (overrun),
    .pulse_cnt(pulse_cnt)
  );

  always #20 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // d as sampled at each rising edge, indexed by edge number
  bit samp [0:19999];
  int k = 4;
  int last_tg = 4;

  bit          m_lvl;
  bit          m_rise;
  bit          m_ov;
  bit          m_osat;
  bit          m_ovf;
  bit          m_rpend;
  bit          m_fpend;
  int          m_start;
  int          m_fw;
  logic [7:0]  m_ow;
  logic [15:0] m_pc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s at edge %0d: got %0h want %0h",
             tag, k, obs, exp);
    end
  endtask

  // Level flips once the last S synced samples (d two edges back)
  // all disagree with it, counting only samples after the last flip.
  task automatic model(input bit dv, input bit rv,
                       input bit rdy);
    bit old;
    bit tg;
    bit xf;
    k++;
    if (!rv) begin
      samp[k] = 1'b0;
      samp[k-1] = 1'b0;
      last_tg = k;
      m_lvl = 0; m_rise = 0; m_ov = 0;
      m_ow = '0; m_osat = 0; m_ovf = 0;
      m_pc = '0; m_rpend = 0; m_fpend = 0;
      return;
    end
    samp[k] = dv;
    xf = m_ov & rdy;
    if (m_fpend) begin
      if (!m_ov || xf) begin
        m_ow = (m_fw > 255) ? 8'd255 : 8'(m_fw);
        m_osat = (m_fw > 255);
        m_ov = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (xf) begin
      m_ov = 1'b0;
    end
    if (m_rpend) m_pc = m_pc + 16'd1;
    m_rpend = 0;
    m_fpend = 0;
    old = m_lvl;
    tg = (k - last_tg >= S);
    for (int j = 0; j < S; j++)
      if (samp[k-2-j] == m_lvl) tg = 1'b0;
    if (tg) begin
      m_lvl = ~m_lvl;
      last_tg = k;
      if (m_lvl) begin
        m_start = k;
        m_rpend = 1'b1;
      end else begin
        m_fw = k - m_start;
        m_fpend = 1'b1;
      end
    end
    m_rise = m_lvl & ~old;
  endtask

  task automatic step(input bit dv, input bit rv,
                      input bit rdy, input int gl);
    d = dv;
    rst_n = rv;
    out_ready = rdy;
    if (gl > 0) begin
      #5;
      d = ~dv;
      #gl;
      d = dv;
    end
    @(posedge clk);
    model(dv, rv, rdy);
    #1;
    chk("level", level, m_lvl);
    chk("rise", rise, m_rise);
    chk("out_valid", out_valid, m_ov);
    chk("out_width", out_width, m_ow);
    chk("out_sat", out_sat, m_osat);
    chk("overrun", overrun, m_ovf);
    chk("pulse_cnt", pulse_cnt, m_pc);
  endtask

  initial begin
    // reset with d toggling
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    repeat (4) step(0, 1, 1, 0);

    // sub-cycle glitches never reach level
    step(0, 1, 1, 2);
    step(0, 1, 1, 22);
    repeat (6) step(0, 1, 1, 0);
    chk("glitch_pcnt", pulse_cnt, 0);
    chk("glitch_level", level, 0);

    // one 5-cycle pulse
    repeat (5) step(1, 1, 1, 0);
    repeat (10) step(0, 1, 1, 0);
    chk("p5_width", out_width, 5);
    chk("p5_pcnt", pulse_cnt, 1);

    // saturating pulse
    repeat (300) step(1, 1, 1, 0);
    repeat (10) step(0, 1, 1, 0);
    chk("p300_width", out_width, 255);
    chk("p300_sat", out_sat, 1);

    // two pulses with consumer stalled
    repeat (3) step(1, 1, 0, 0);
    repeat (7) step(0, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    repeat (10) step(0, 1, 0, 0);
    chk("ovr_width", out_width, 3);
    chk("ovr_flag", overrun, 1);
    step(0, 1, 1, 0);
    chk("ovr_drain", out_valid, 0);
    step(0, 1, 0, 0);

    // reset in the middle of a filtered high
    repeat (5) step(1, 1, 1, 0);
    chk("mid_level", level, 1);
    step(1, 0, 1, 0);
    repeat (10) step(0, 1, 1, 0);
    chk("mid_level0", level, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_pcnt", pulse_cnt, 0);

    // random segments, random ready, glitches, rare resets
    for (int i = 0; i < 160; i++) begin
      int len;
      bit rv;
      len = $urandom_range(1, 12);
      rv = ($urandom_range(0, 40) != 0);
      for (int c = 0; c < len; c++) begin
        int gl;
        gl = ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, 25)) : 0;
        step(i[0], (c == 0) ? rv : 1'b1,
             1'($urandom_range(0, 1)), gl);
      end
    end
    repeat (12) step(0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
